// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port memory between fetch and data paths
// One access in flight at a time: IDLE -> ISSUE -> WAIT (MEM_LAT-1 cycles) -> DONE.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t            state_q;
    logic              rr_last_q;
    logic              owner_q;
    logic              we_q;
    logic              en_q;
    logic              if_ack_q;
    logic              d_ack_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              any_req;
    logic              pick_d;
    logic              capture;
    logic [ADDR_W-1:0] sel_addr;

    // Data wins only when fetch is idle or fetch owned the previous grant.
    always_comb begin
        any_req       = if_req | d_req;
        pick_d        = d_req & (~if_req | ~rr_last_q);
        sel_addr      = pick_d ? d_addr : if_addr;
        sel_addr[1:0] = 2'b00;
        capture       = ((state_q == ISSUE) && (MEM_LAT == 1)) ||
                        ((state_q == WAIT) && (cnt_q == 4'd1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_last_q  <= 1'b1;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            en_q       <= 1'b0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q   <= ISSUE;
                        owner_q   <= pick_d;
                        rr_last_q <= pick_d;
                        we_q      <= pick_d & d_we;
                        addr_q    <= sel_addr;
                        wdata_q   <= (pick_d & d_we) ? d_wdata : '0;
                        en_q      <= 1'b1;
                    end
                end
                ISSUE: begin
                    en_q    <= 1'b0;
                    cnt_q   <= LAT_M1;
                    state_q <= (MEM_LAT == 1) ? DONE : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (capture) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // Read data lands in the owner's register on the same edge that enters DONE.
            if (capture) begin
                if (owner_q) begin
                    d_ack_q <= 1'b1;
                    if (!we_q) begin
                        d_rdata_q <= mem_rdata;
                    end
                end else begin
                    if_ack_q   <= 1'b1;
                    if_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign if_ack      = if_ack_q;
    assign if_rdata    = if_rdata_q;
    assign d_ack       = d_ack_q;
    assign d_rdata     = d_rdata_q;
    assign mem_en      = en_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign busy        = (state_q != IDLE);
    assign grant_owner = owner_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port memory between the CPU's instruction-fetch path (PC/instruction) and its data path (dataAddress/MemRead/MemWrite). A multi-cycle FSM issues one access at a time with fixed memory latency and returns results through a req/ack handshake per requester. Round-robin arbitration prevents starvation. The block sits between the CPU and a shared memory model; `busy` is the CPU stall source.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the issue cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address (PC).
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  DATA_W  fetched instruction; valid while if_ack is high, then held.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write (MemWrite), 0 = read (MemRead).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle completion pulse for data.
- d_rdata  out  DATA_W  load data; updated only by read completions.
- mem_en  out  1  memory access strobe; high for exactly the issue cycle.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  word address, formed as {addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state is not IDLE.
- grant_owner  out  1  current owner: 0 = fetch, 1 = data; meaningful only while busy.

Behaviour:
- **Reset (asynchronous):** state=IDLE; rr_last=1 (data), so fetch wins the first tie. All outputs are 0, including if_rdata and d_rdata; wait counter=0.
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - Samples if_req and d_req.
  - One request: grant it.
  - Both requests: grant the requester that is not rr_last.
  - Neither: stay in IDLE.
  - On grant: register owner, we, addr, wdata; set rr_last=owner; go to ISSUE.
- **ISSUE (1 cycle):** mem_en=1, mem_we=latched we, mem_addr and mem_wdata from latched values; counter=MEM_LAT-1. Go to WAIT, or to DONE directly when MEM_LAT=1 (capture occurs on the ISSUE-exit edge).
- **WAIT:**
  - Counter decrements each cycle.
  - When the counter reaches 0, capture mem_rdata on that edge into the owner's rdata register (reads only) and go to DONE.
  - mem_en=0 throughout; mem_addr, mem_we and mem_wdata hold their ISSUE values.
- **DONE (1 cycle):** owner's ack=1; rdata valid. Always go to IDLE; requests are not sampled in DONE.
- **Latency:** req seen in IDLE at cycle 0 → mem_en at cycle 1 → mem_rdata sampled at end of cycle 1+MEM_LAT-1 → ack at cycle MEM_LAT+1 → IDLE at MEM_LAT+2.
  - Back-to-back throughput: one access per MEM_LAT+2 cycles.
- **Handshake:**
  - A requester keeps req, addr, we and wdata stable until its ack cycle.
  - req still high in the cycle after ack counts as a new request.
  - Dropping req before grant means no transaction. Dropping req after grant has no effect; the access completes and ack still pulses.
- **Ack rules:** if_ack and d_ack are never high together; each pulse lasts exactly 1 cycle.
- **Writes:** d_rdata is unchanged. d_ack timing is the same as for reads.
- **Starvation bound:** with both requesters held high, grants alternate IF, D, IF, D, …
- **Reset mid-operation:** any state goes to IDLE immediately; the in-flight access is abandoned with no ack. mem_en drops asynchronously.
- **X on an unrequested channel:** ignored, never propagated to mem_* outputs.

Test Plan:
1. **Single fetch, MEM_LAT=2.** Stimulus: if_req=1, if_addr=0x3000, memory[0x3000]=0x8C010004.
   - Required: mem_en at cycle 1 with mem_addr=0x3000 and mem_we=0.
   - Required: if_ack at cycle 3, if_rdata=0x8C010004, busy low at cycle 4.
2. **Simultaneous requests from reset, held.** Stimulus: if_req and d_req both held high.
   - Required: grants in order IF, D, IF, D.
   - Required: acks at cycles 3, 7, 11, 15; never both acks at once.
3. **Data write.** Stimulus: d_req=1, d_we=1, d_addr=0x0006, d_wdata=0xDEADBEEF.
   - Required: mem_addr=0x0004, mem_we=1, mem_wdata=0xDEADBEEF.
   - Required: d_ack at cycle 3; d_rdata unchanged (0).
4. **MEM_LAT=1.** Stimulus: a single data read of 0x0010 returning 0x12345678.
   - Required: d_ack at cycle 2 with d_rdata=0x12345678.
5. **Reset asserted during WAIT.** Stimulus: assert reset while a fetch is in WAIT.
   - Required: busy=0, mem_en=0, no if_ack, if_rdata=0.
   - Required: after release, the next request wins from IDLE with fetch priority.
6. **Early req drop.** Stimulus: d_req is pulsed for 1 cycle while a fetch is busy.
   - Required: no data transaction and no d_ack.
   - Required: after a d_req is granted, dropping it still yields d_ack at the scheduled cycle.
